video_stream_gen: RTL and testbench

VIDEO_STREAM_GEN -- requirements
Module: video_stream_gen

---
 rtl/video_stream_gen.sv | 157 +++++++++++++++
 tb/tb_video_stream_gen.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/video_stream_gen.sv
// Frame generator that turns a valid/ready pixel stream into registered
// vsync/href/clken/data video timing, one frame per enable-qualified start.
module video_stream_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int V_ACTIVE  = 480,
    parameter int H_BLANK   = 16,
    parameter int V_BLANK   = 8,
    parameter int VSYNC_LEN = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       enable,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic       per_frame_vsync,
    output logic       per_frame_href,
    output logic       per_frame_clken,
    output logic [7:0] per_frame_data,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_VSYNC,
        S_VBLANK,
        S_LINE,
        S_HBLANK
    } state_t;

    // Blank/sync counters count down from length-1 and are reloaded on state entry.
    localparam logic [15:0] VSYNC_LOAD  = 16'(VSYNC_LEN - 1);
    localparam logic [15:0] VBLANK_LOAD = 16'(V_BLANK - 1);
    localparam logic [15:0] HBLANK_LOAD = 16'(H_BLANK - 1);
    localparam logic [10:0] COL_LAST    = 11'(H_ACTIVE - 1);
    localparam logic [10:0] COL_LIMIT   = 11'(H_ACTIVE);
    localparam logic [10:0] LINE_LIMIT  = 11'(V_ACTIVE);

    state_t      state_q, state_d;
    logic [10:0] col_q, col_d;
    logic [10:0] line_q, line_d;
    logic [15:0] cnt_q, cnt_d;
    logic        transfer;
    logic        frame_end;

    logic       vsync_q, href_q, clken_q, done_q;
    logic [7:0] data_q;

    assign s_ready  = (state_q == S_LINE) && (col_q < COL_LIMIT);
    assign transfer = s_valid && s_ready;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        cnt_d     = cnt_q;
        frame_end = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_VSYNC;
                    cnt_d   = VSYNC_LOAD;
                    line_d  = '0;
                end
            end
            S_VSYNC: begin
                line_d = '0;
                if (cnt_q == '0) begin
                    state_d = S_VBLANK;
                    cnt_d   = VBLANK_LOAD;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_VBLANK: begin
                if (cnt_q == '0) begin
                    state_d = S_LINE;
                    col_d   = '0;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            S_LINE: begin
                // The last transfer of the line moves straight to HBLANK so
                // href covers exactly the cycles that can carry a pixel.
                if (transfer) begin
                    col_d = col_q + 11'd1;
                    if (col_q == COL_LAST) begin
                        state_d = S_HBLANK;
                        cnt_d   = HBLANK_LOAD;
                        line_d  = line_q + 11'd1;
                    end
                end
            end
            S_HBLANK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 16'd1;
                end else if (line_q < LINE_LIMIT) begin
                    state_d = S_LINE;
                    col_d   = '0;
                end else begin
                    frame_end = 1'b1;
                    if (enable) begin
                        state_d = S_VSYNC;
                        cnt_d   = VSYNC_LOAD;
                        line_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            line_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs describe the previous cycle's state and transfer.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            done_q  <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            vsync_q <= (state_q == S_VSYNC);
            href_q  <= (state_q == S_LINE);
            clken_q <= transfer;
            done_q  <= frame_end;
            if (transfer) begin
                data_q <= s_data;
            end
        end
    end

    assign per_frame_vsync = vsync_q;
    assign per_frame_href  = href_q;
    assign per_frame_clken = clken_q;
    assign per_frame_data  = data_q;
    assign frame_done      = done_q;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen with a 4x2 frame; every output is
// compared each cycle against hand-derived timing vectors.
module tb_video_stream_gen;

    logic       clock = 1'b0;
    logic       rst;
    logic       enable;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic       per_frame_vsync;
    logic       per_frame_href;
    logic       per_frame_clken;
    logic [7:0] per_frame_data;
    logic       frame_done;

    int total = 0;
    int bad   = 0;
    int npix  = 0;
    logic [7:0]  exp_px = 8'd0;
    logic [63:0] v_exp, h_exp, c_exp, f_exp, r_exp;

    video_stream_gen #(
        .H_ACTIVE (4),
        .V_ACTIVE (2),
        .H_BLANK  (2),
        .V_BLANK  (3),
        .VSYNC_LEN(2)
    ) dut (
        .clock          (clock),
        .rst            (rst),
        .enable         (enable),
        .s_valid        (s_valid),
        .s_data         (s_data),
        .s_ready        (s_ready),
        .per_frame_vsync(per_frame_vsync),
        .per_frame_href (per_frame_href),
        .per_frame_clken(per_frame_clken),
        .per_frame_data (per_frame_data),
        .frame_done     (frame_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, k, obs, expv);
        end
    endtask

    // One clock: the source advances its pixel only when it was accepted.
    task automatic step();
        logic x;
        x = s_valid && s_ready;
        @(posedge clock);
        #1;
        if (x) s_data = s_data + 8'd1;
    endtask

    task automatic cyc_chk(input string run, input int k);
        chk({run, "_vsync"}, k, {7'd0, per_frame_vsync}, {7'd0, v_exp[k]});
        chk({run, "_href"},  k, {7'd0, per_frame_href},  {7'd0, h_exp[k]});
        chk({run, "_clken"}, k, {7'd0, per_frame_clken}, {7'd0, c_exp[k]});
        chk({run, "_done"},  k, {7'd0, frame_done},      {7'd0, f_exp[k]});
        chk({run, "_ready"}, k, {7'd0, s_ready},         {7'd0, r_exp[k]});
        if (per_frame_clken) npix++;
        if (c_exp[k]) begin
            chk({run, "_data"}, k, per_frame_data, exp_px);
            exp_px = exp_px + 8'd1;
        end
    endtask

    task automatic zero_chk(input string tag, input int k);
        chk({tag, "_vsync"}, k, {7'd0, per_frame_vsync}, 8'd0);
        chk({tag, "_href"},  k, {7'd0, per_frame_href},  8'd0);
        chk({tag, "_clken"}, k, {7'd0, per_frame_clken}, 8'd0);
        chk({tag, "_done"},  k, {7'd0, frame_done},      8'd0);
        chk({tag, "_ready"}, k, {7'd0, s_ready},         8'd0);
        chk({tag, "_data"},  k, per_frame_data,          8'h00);
    endtask

    initial begin
        rst     = 1'b1;
        enable  = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'd0;
        step();
        step();
        zero_chk("reset", 0);
        rst = 1'b0;

        // Two back-to-back frames; enable drops during line 1 of frame 2.
        v_exp = 64'h0000_0000_0018_000C;
        h_exp = 64'h0000_0003_CF01_E780;
        c_exp = h_exp;
        f_exp = 64'h0000_0008_0004_0000;
        r_exp = h_exp >> 1;
        enable  = 1'b1;
        s_valid = 1'b1;
        npix    = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            cyc_chk("b2b", k);
            if (k == 25) enable = 1'b0;
        end
        chk("b2b_pixels", 40, 8'(npix), 8'd16);

        // Single frame: 3-cycle stall after pixel 2 of line 1, enable dropped in line 1.
        v_exp = 64'h0000_0000_0000_000C;
        h_exp = 64'h0000_0000_000F_3F80;
        c_exp = 64'h0000_0000_000F_3180;
        f_exp = 64'h0000_0000_0020_0000;
        r_exp = h_exp >> 1;
        enable  = 1'b1;
        s_valid = 1'b1;
        npix    = 0;
        for (int j = 1; j <= 30; j++) begin
            step();
            cyc_chk("stall", j);
            s_valid = (j < 8) || (j > 10);
            if (j == 7) enable = 1'b0;
        end
        chk("stall_pixels", 30, 8'(npix), 8'd8);

        // Reset during line 2 with its 3rd pixel pending, then restart.
        v_exp = 64'h0000_0000_0018_000C;
        h_exp = 64'h0000_0003_CF01_E780;
        c_exp = h_exp;
        f_exp = 64'h0000_0008_0004_0000;
        r_exp = h_exp >> 1;
        enable  = 1'b1;
        s_valid = 1'b1;
        for (int j = 1; j <= 14; j++) begin
            step();
            cyc_chk("pre_rst", j);
        end
        rst = 1'b1;
        #1;
        zero_chk("mid_rst", 14);
        step();
        zero_chk("held_rst", 15);
        rst  = 1'b0;
        npix = 0;
        for (int k = 1; k <= 19; k++) begin
            step();
            cyc_chk("restart", k);
        end
        chk("restart_pixels", 19, 8'(npix), 8'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
